// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Decode-stage interlock for a single-issue in-order pipeline. Tracks pending
//   register writes with a 2-bit counter per architectural register (x1..x31),
//   holds decode on RAW hazards or a saturated destination counter, and
//   sequences branch resolution (wait for resolve, then flush IF/ID for
//   FLUSH_CYCLES cycles on a taken branch).
//
// Parameters
//   FLUSH_CYCLES   1..7, cycles flush_o stays high after a taken branch.
//
// Configuration macro
//   HAZARD_WB_BYPASS_EN  when defined, a source with exactly one pending write
//                        that retires in the same cycle is not a hazard (the
//                        register file writes through to the read port).
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   id_valid_i                decode holds a valid instruction
//   id_rs1_i, id_rs2_i [4:0]  source registers (0 when unused)
//   id_rd_i [4:0]             destination register
//   id_rf_wr_en_i             instruction writes id_rd_i
//   id_is_branch_i            instruction is JAL/JALR/branch
//   ex_ready_i                execute can accept an instruction
//   wb_valid_i, wb_rd_i [4:0] writeback commits a write to wb_rd_i
//   br_resolve_i, br_taken_i  execute resolves the outstanding branch
//   issue_o                   instruction moves decode->execute this cycle
//   stall_o                   hold PC and IF/ID
//   flush_o                   invalidate IF/ID
//   busy_mask_o [31:0]        bit n = register n has a pending write
//   state_o [1:0]             0 RUN, 1 BR_WAIT, 2 FLUSH
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rf_wr_en_i,
  input  logic        id_is_branch_i,
  input  logic        ex_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        br_resolve_i,
  input  logic        br_taken_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] busy_mask_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  // Per-register pending-write counters; x0 has no storage.
  logic [1:0]        cnt_q [1:31];
  // Flattened view with x0 tied to zero so lookups need no special case.
  logic [31:0][1:0]  cnt_all;

  always_comb begin
    cnt_all[0] = 2'd0;
    for (int n = 1; n < 32; n++) begin
      cnt_all[n] = cnt_q[n];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic [1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic       rs1_byp, rs2_byp;
  logic       rs1_haz, rs2_haz, rd_haz, hazard;

  assign rs1_cnt = cnt_all[id_rs1_i];
  assign rs2_cnt = cnt_all[id_rs2_i];
  assign rd_cnt  = cnt_all[id_rd_i];

`ifdef HAZARD_WB_BYPASS_EN
  // The last outstanding write retiring this cycle is visible through the
  // register file, so the read can proceed.
  assign rs1_byp = (rs1_cnt == 2'd1) && wb_valid_i && (wb_rd_i == id_rs1_i);
  assign rs2_byp = (rs2_cnt == 2'd1) && wb_valid_i && (wb_rd_i == id_rs2_i);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_haz = (id_rs1_i != 5'd0) && (rs1_cnt != 2'd0) && !rs1_byp;
  assign rs2_haz = (id_rs2_i != 5'd0) && (rs2_cnt != 2'd0) && !rs2_byp;
  // A saturated counter cannot record another pending write.
  assign rd_haz  = id_rf_wr_en_i && (id_rd_i != 5'd0) && (rd_cnt == 2'd3);
  assign hazard  = rs1_haz || rs2_haz || rd_haz;

  // ---------------------------------------------------------------------------
  // Outputs (gated by rst so they read 0 for the whole reset window)
  // ---------------------------------------------------------------------------
  assign issue_o = !rst && (state_q == ST_RUN) && id_valid_i && ex_ready_i && !hazard;
  assign stall_o = !rst && id_valid_i && !issue_o && (state_q != ST_FLUSH);
  assign flush_o = !rst && (state_q == ST_FLUSH);
  assign state_o = state_q;

  always_comb begin
    busy_mask_o = '0;
    for (int n = 1; n < 32; n++) begin
      busy_mask_o[n] = (cnt_q[n] != 2'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  for (genvar n = 1; n < 32; n++) begin : g_cnt
    logic inc, dec;
    assign inc = issue_o && id_rf_wr_en_i && (id_rd_i == 5'(n));
    // A retire to an idle register is dropped rather than wrapping.
    assign dec = wb_valid_i && (wb_rd_i == 5'(n)) && (cnt_q[n] != 2'd0);

    // NOTE: the counter array is reset (not left as uninitialised storage)
    // because busy_mask_o and the hazard logic read it from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q[n] <= 2'd0;
      end else if (inc && !dec) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        cnt_q[n] <= cnt_q[n] + 2'd1;
      end else if (dec && !inc) begin
        cnt_q[n] <= cnt_q[n] - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Branch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (issue_o && id_is_branch_i) state_d = ST_BR_WAIT;
      end
      ST_BR_WAIT: begin
        if (br_resolve_i) begin
          if (br_taken_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. A behavioural model (integer pending
//   counts per register, a mode number and a flush countdown) predicts every
//   output each cycle; directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rf_wr_en, id_is_branch, ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        br_resolve, br_taken;
  logic        issue_o, stall_o, flush_o;
  logic [31:0] busy_mask_o;
  logic [1:0]  state_o;

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_rf_wr_en_i (id_rf_wr_en),
    .id_is_branch_i(id_is_branch),
    .ex_ready_i    (ex_ready),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .br_resolve_i  (br_resolve),
    .br_taken_i    (br_taken),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .busy_mask_o   (busy_mask_o),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0 run, 1 waiting for branch, 2 flushing.
  int m_cnt [32];
  int m_mode;
  int m_left;

  logic        e_issue, e_stall, e_flush;
  logic [31:0] e_busy;
  logic [1:0]  e_state;

`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_mode = 0;
    m_left = 0;
  endtask

  task automatic model_expect();
    bit haz;
    haz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int r;
      r = (k == 0) ? int'(id_rs1) : int'(id_rs2);
      if (r != 0 && m_cnt[r] != 0) begin
        if (!(BYPASS && m_cnt[r] == 1 && wb_valid && int'(wb_rd) == r)) haz = 1'b1;
      end
    end
    if (id_rf_wr_en && id_rd != 0 && m_cnt[id_rd] == 3) haz = 1'b1;
    e_issue = (m_mode == 0) && id_valid && ex_ready && !haz;
    e_stall = id_valid && !e_issue && (m_mode != 2);
    e_flush = (m_mode == 2);
    e_state = 2'(m_mode);
    e_busy  = '0;
    for (int n = 1; n < 32; n++) e_busy[n] = (m_cnt[n] > 0);
    if (rst) begin
      e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_busy = '0; e_state = 2'd0;
    end
  endtask

  task automatic model_update();
    int pre;
    pre = m_cnt[wb_rd];
    if (e_issue && id_rf_wr_en && id_rd != 0) m_cnt[id_rd] = m_cnt[id_rd] + 1;
    if (wb_valid && wb_rd != 0 && pre > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
    case (m_mode)
      0: if (e_issue && id_is_branch) m_mode = 1;
      1: if (br_resolve) begin
           if (br_taken) begin m_mode = 2; m_left = FC; end
           else m_mode = 0;
         end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  // Called with inputs set just after a falling edge; checks the model, runs
  // one rising edge, and returns on the next falling edge.
  task automatic tick();
    #1;
    model_expect();
    check("issue", 32'(issue_o), 32'(e_issue));
    check("stall", 32'(stall_o), 32'(e_stall));
    check("flush", 32'(flush_o), 32'(e_flush));
    check("busy",  busy_mask_o, e_busy);
    check("state", 32'(state_o), 32'(e_state));
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rf_wr_en = 0;
    id_is_branch = 0; ex_ready = 1; wb_valid = 0; wb_rd = 0;
    br_resolve = 0; br_taken = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic br);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rf_wr_en = wr; id_is_branch = br;
  endtask

  // Asynchronous reset pulse starting mid-cycle; returns on a falling edge
  // with rst released.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_issue", 32'(issue_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_busy",  busy_mask_o, 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    id_valid = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_issue", 32'(issue_o), 32'd0);
    check("init_stall", 32'(stall_o), 32'd0);
    check("init_state", 32'(state_o), 32'd0);
    check("init_busy",  busy_mask_o, 32'd0);
    rst = 1'b0;
    idle();

    // --- RAW on x5 ---------------------------------------------------------
    instr(0, 0, 5, 1, 0);
    #1 check("raw_first_issue", 32'(issue_o), 32'd1);
    tick();
    instr(5, 0, 0, 0, 0);
    #1 check("raw_stall_issue", 32'(issue_o), 32'd0);
    check("raw_stall", 32'(stall_o), 32'd1);
    check("raw_busy5", 32'(busy_mask_o[5]), 32'd1);
    tick();
    wb_valid = 1; wb_rd = 5;
    #1 check("raw_wb_issue", 32'(issue_o), BYPASS ? 32'd1 : 32'd0);
    tick();
    wb_valid = 0;
    if (!BYPASS) begin
      #1 check("raw_late_issue", 32'(issue_o), 32'd1);
      tick();
    end
    idle();
    #1 check("raw_busy_clear", busy_mask_o, 32'd0);
    tick();

    // --- Saturating x7 -----------------------------------------------------
    for (int i = 0; i < 3; i++) begin
      instr(0, 0, 7, 1, 0);
      #1 check("sat_issue", 32'(issue_o), 32'd1);
      tick();
    end
    instr(0, 0, 7, 1, 0);
    #1 check("sat_fourth_stall", 32'(stall_o), 32'd1);
    tick();
    wb_valid = 1; wb_rd = 7;
    #1 check("sat_wb_cycle_issue", 32'(issue_o), 32'd0);
    tick();
    wb_valid = 0;
    #1 check("sat_fourth_issue", 32'(issue_o), 32'd1);
    tick();
    idle();
    #1 check("sat_busy7", busy_mask_o, 32'h0000_0080);
    tick();
    wb_valid = 1; wb_rd = 7;
    repeat (3) tick();
    idle();
    #1 check("sat_drained", busy_mask_o, 32'd0);
    tick();

    // --- Taken branch ------------------------------------------------------
    instr(0, 0, 0, 0, 1);
    #1 check("br_issue", 32'(issue_o), 32'd1);
    tick();
    idle();
    #1 check("br_wait_state", 32'(state_o), 32'd1);
    tick();
    br_resolve = 1; br_taken = 1;
    tick();
    idle();
    instr(0, 0, 0, 0, 0);
    for (int i = 0; i < FC; i++) begin
      #1 check("tk_flush", 32'(flush_o), 32'd1);
      check("tk_state", 32'(state_o), 32'd2);
      check("tk_no_issue", 32'(issue_o), 32'd0);
      check("tk_no_stall", 32'(stall_o), 32'd0);
      tick();
    end
    #1 check("tk_done_flush", 32'(flush_o), 32'd0);
    check("tk_done_state", 32'(state_o), 32'd0);
    check("tk_resume_issue", 32'(issue_o), 32'd1);
    tick();

    // --- Not-taken branch --------------------------------------------------
    instr(0, 0, 0, 0, 1);
    tick();
    idle();
    br_resolve = 1; br_taken = 0;
    #1 check("nt_wait_state", 32'(state_o), 32'd1);
    tick();
    idle();
    #1 check("nt_state", 32'(state_o), 32'd0);
    check("nt_flush", 32'(flush_o), 32'd0);
    tick();

    // --- x0 never tracked --------------------------------------------------
    for (int i = 0; i < 4; i++) begin
      instr(0, 0, 0, 1, 0);
      #1 check("x0_issue", 32'(issue_o), 32'd1);
      check("x0_busy", busy_mask_o, 32'd0);
      tick();
    end
    idle();
    wb_valid = 1; wb_rd = 9;
    tick();
    idle();
    #1 check("idle_retire_busy", busy_mask_o, 32'd0);
    tick();

    // --- Reset during FLUSH with x3 pending --------------------------------
    instr(0, 0, 3, 1, 0);
    tick();
    instr(0, 0, 0, 0, 1);
    tick();
    idle();
    br_resolve = 1; br_taken = 1;
    tick();
    idle();
    id_valid = 1;
    #1 check("rf_in_flush", 32'(state_o), 32'd2);
    pulse_reset();
    idle();
    #1 check("rf_after_state", 32'(state_o), 32'd0);
    check("rf_after_busy", busy_mask_o, 32'd0);
    tick();

    // --- Randomized traffic ------------------------------------------------
    for (int c = 0; c < 3000; c++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rf_wr_en  = ($urandom_range(0, 9) < 7);
      id_is_branch = ($urandom_range(0, 9) == 0);
      ex_ready     = ($urandom_range(0, 4) != 0);
      wb_valid     = ($urandom_range(0, 1) == 1);
      wb_rd        = 5'($urandom_range(0, 7));
      br_resolve   = ($urandom_range(0, 2) == 0);
      br_taken     = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, range 1..7; number of cycles flush_o is held after a taken branch.
REQ-002 clk  in  1  single core clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 id_valid_i  in  1  decode stage holds a valid instruction.
REQ-005 id_rs1_i / id_rs2_i  in  5 each  source register indices from decode (0 when unused).
REQ-006 id_rd_i  in  5; id_rf_wr_en_i  in  1  destination index and write enable from decode.
REQ-007 id_is_branch_i  in  1  instruction is JAL/JALR/branch.
REQ-008 ex_ready_i  in  1  execute stage can accept an instruction this cycle.
REQ-009 wb_valid_i  in  1; wb_rd_i  in  5  writeback commits a register-file write to wb_rd_i.
REQ-010 br_resolve_i  in  1; br_taken_i  in  1  execute resolves the outstanding branch; taken = redirect.
REQ-011 issue_o  out  1  instruction moves decode->execute this cycle.
REQ-012 stall_o  out  1  hold PC and IF/ID register.
REQ-013 flush_o  out  1  invalidate IF/ID contents.
REQ-014 busy_mask_o  out  32  bit n = register n has at least one pending write.
REQ-015 state_o  out  2  FSM state: 0 RUN, 1 BR_WAIT, 2 FLUSH.

Function
REQ-016 Scoreboard: one 2-bit pending-write counter per register x1..x31; x0 never tracked, its counter and busy bit always 0.
REQ-017 Hazard: rs1 or rs2 non-zero with counter != 0, or id_rf_wr_en_i=1, id_rd_i != 0, and rd counter == 3.
REQ-018 issue_o = (state==RUN) & id_valid_i & ex_ready_i & ~hazard; combinational, same cycle.
REQ-019 stall_o = id_valid_i & ~issue_o & (state != FLUSH); stall_o=0 in FLUSH.
REQ-020 Counter update per edge: +1 on issue with id_rf_wr_en_i=1 and id_rd_i!=0; -1 on wb_valid_i with wb_rd_i!=0; both on same register -> unchanged.
REQ-021 Retire to a counter already 0: counter stays 0, no other effect.
REQ-022 RUN -> BR_WAIT on the edge where issue_o=1 and id_is_branch_i=1.
REQ-023 BR_WAIT: issue_o=0; br_resolve_i with br_taken_i=1 -> FLUSH; br_resolve_i with br_taken_i=0 -> RUN.
REQ-024 br_resolve_i in RUN or FLUSH is ignored.
REQ-025 FLUSH: flush_o=1 for exactly FLUSH_CYCLES consecutive cycles (3-bit down-counter), then -> RUN; flush_o=0 in all other states.
REQ-026 Scoreboard keeps updating from writeback in every state; pending writes are not cancelled by a flush.
REQ-027 busy_mask_o is registered-state derived: bit n = (counter[n] != 0).

Reset
REQ-028 While rst=1: all counters 0, state RUN, flush counter 0, and issue_o, stall_o, flush_o, busy_mask_o, state_o all 0.
REQ-029 Reset asserted mid-BR_WAIT or mid-FLUSH aborts the sequence immediately; first cycle after release is RUN with an empty scoreboard.

Configuration
REQ-030 Macro HAZARD_WB_BYPASS_EN: when defined, a source whose counter == 1 does not cause a hazard if wb_valid_i=1 and wb_rd_i equals that source in the same cycle (register file write-through).
REQ-031 Without HAZARD_WB_BYPASS_EN, any non-zero source counter stalls, including during a matching writeback cycle.

Verification
REQ-032 Issue add x5 (rd=5), next cycle decode reads rs1=5, no writeback -> issue_o=0, stall_o=1, busy_mask_o[5]=1; wb_rd_i=5 next -> issue_o=1 (bypass on) or one cycle later (bypass off).
REQ-033 Three issues writing x7 without writeback, fourth writing x7 -> fourth stalls (counter 3); one wb_rd_i=7 -> fourth issues, counter returns to 3.
REQ-034 Issue branch, br_resolve_i=1 br_taken_i=1 two cycles later -> state_o 1->2, flush_o=1 for exactly 2 cycles, then state_o=0 and issue resumes.
REQ-035 Issue branch, resolve not-taken -> state_o returns to 0 with flush_o never asserted.
REQ-036 Instruction with rd=0, rs1=0 issued repeatedly -> busy_mask_o stays 0, never stalls; wb_rd_i=9 with counter 0 -> busy_mask_o[9] stays 0.
REQ-037 rst pulse during FLUSH with pending x3 -> all outputs 0 during reset, afterwards state_o=0, busy_mask_o=0.
